// File: rtl/idma_obi_sram_adapter.sv
// OBI subordinate that terminates an iDMA OBI port on a single-port SRAM bank.
// Grants are credit-throttled so the fall-through response FIFO can never overflow.
module idma_obi_sram_adapter #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned IdWidth       = 1,
    parameter int unsigned SramAddrWidth = 10,
    parameter int unsigned SramLatency   = 1,
    parameter int unsigned RspFifoDepth  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     obi_req_i,
    output logic                     obi_gnt_o,
    input  logic [AddrWidth-1:0]     obi_addr_i,
    input  logic                     obi_we_i,
    input  logic [DataWidth/8-1:0]   obi_be_i,
    input  logic [DataWidth-1:0]     obi_wdata_i,
    input  logic [IdWidth-1:0]       obi_aid_i,
    output logic                     obi_rvalid_o,
    input  logic                     obi_rready_i,
    output logic [DataWidth-1:0]     obi_rdata_o,
    output logic [IdWidth-1:0]       obi_rid_o,
    output logic                     obi_err_o,
    output logic                     sram_req_o,
    output logic                     sram_we_o,
    output logic [SramAddrWidth-1:0] sram_addr_o,
    output logic [DataWidth/8-1:0]   sram_be_o,
    output logic [DataWidth-1:0]     sram_wdata_o,
    input  logic [DataWidth-1:0]     sram_rdata_i
);

    localparam int unsigned StrbWidth   = DataWidth / 8;
    localparam int unsigned OffsetWidth = $clog2(StrbWidth);
    localparam int unsigned CntWidth    = $clog2(RspFifoDepth + 1);
    localparam int unsigned PtrWidth    = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(RspFifoDepth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(RspFifoDepth - 1);

    if (SramLatency < 1 || RspFifoDepth < 1) begin : gen_param_error
        $error("idma_obi_sram_adapter: SramLatency and RspFifoDepth must both be >= 1");
    end
    if (RspFifoDepth < SramLatency) begin : gen_depth_warning
        $warning("idma_obi_sram_adapter: RspFifoDepth < SramLatency limits sustained throughput");
    end

    logic                     outOfRange;
    logic                     transfer;
    logic                     sramReq;
    logic                     rvalid;
    logic                     pop;
    logic                     lastValid;
    logic [DataWidth-1:0]     pushData;
    logic [IdWidth-1:0]       pushId;
    logic                     pushErr;
    logic                     fifoEmpty;
    logic                     storeEn;
    logic                     popStored;

    logic [SramLatency-1:0]   pipeValid_q;
    logic [SramLatency-1:0]   pipeWe_q;
    logic [SramLatency-1:0]   pipeErr_q;
    logic [IdWidth-1:0]       pipeId_q [SramLatency];

    logic [DataWidth-1:0]     rspData_q [RspFifoDepth];
    logic [IdWidth-1:0]       rspId_q   [RspFifoDepth];
    logic                     rspErr_q  [RspFifoDepth];

    logic [CntWidth-1:0]      creditCnt_q, creditCnt_d;
    logic [CntWidth-1:0]      fifoCount_q, fifoCount_d;
    logic [PtrWidth-1:0]      wrPtr_q, wrPtr_d;
    logic [PtrWidth-1:0]      rdPtr_q, rdPtr_d;

    function automatic logic [PtrWidth-1:0] ptrInc(input logic [PtrWidth-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrWidth'(1);
    endfunction

    // Only the word index and the upper range bits matter; byte alignment is carried by be.
    if (AddrWidth > OffsetWidth + SramAddrWidth) begin : gen_range_check
        assign outOfRange = |obi_addr_i[AddrWidth-1:OffsetWidth+SramAddrWidth];
    end else begin : gen_no_range_check
        assign outOfRange = 1'b0;
    end
    if (OffsetWidth > 0) begin : gen_unused_lsbs
        logic unusedAddrLsbs;
        assign unusedAddrLsbs = ^obi_addr_i[OffsetWidth-1:0];
    end

    assign rvalid    = !rst_i && (!fifoEmpty || lastValid);
    assign pop       = rvalid && obi_rready_i;
    assign obi_gnt_o = obi_req_i && !rst_i && ((creditCnt_q < DepthCnt) || pop);
    assign transfer  = obi_gnt_o;
    assign sramReq   = transfer && !outOfRange;

    assign sram_req_o   = sramReq;
    assign sram_we_o    = sramReq && obi_we_i;
    assign sram_addr_o  = sramReq ? obi_addr_i[OffsetWidth +: SramAddrWidth] : '0;
    assign sram_be_o    = sramReq ? obi_be_i : '0;
    assign sram_wdata_o = sramReq ? obi_wdata_i : '0;

    // Every accepted transfer, including out-of-range ones, walks the latency pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipeValid_q <= '0;
        end else begin
            pipeValid_q[0] <= transfer;
            for (int i = 1; i < SramLatency; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        pipeWe_q[0]  <= obi_we_i;
        pipeErr_q[0] <= outOfRange;
        pipeId_q[0]  <= obi_aid_i;
        for (int i = 1; i < SramLatency; i++) begin
            pipeWe_q[i]  <= pipeWe_q[i-1];
            pipeErr_q[i] <= pipeErr_q[i-1];
            pipeId_q[i]  <= pipeId_q[i-1];
        end
    end

    assign lastValid = pipeValid_q[SramLatency-1];
    assign pushId    = pipeId_q[SramLatency-1];
    assign pushErr   = pipeErr_q[SramLatency-1];
    assign pushData  = (!pipeWe_q[SramLatency-1] && !pushErr) ? sram_rdata_i : '0;

    // An entry arriving at an empty FIFO that is popped the same cycle bypasses storage.
    assign fifoEmpty = (fifoCount_q == '0);
    assign storeEn   = lastValid && !(fifoEmpty && pop);
    assign popStored = pop && !fifoEmpty;

    always_comb begin
        creditCnt_d = creditCnt_q;
        fifoCount_d = fifoCount_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        if (transfer && !pop) begin
            creditCnt_d = creditCnt_q + CntWidth'(1);
        end else if (!transfer && pop) begin
            creditCnt_d = creditCnt_q - CntWidth'(1);
        end
        if (storeEn && !popStored) begin
            fifoCount_d = fifoCount_q + CntWidth'(1);
        end else if (!storeEn && popStored) begin
            fifoCount_d = fifoCount_q - CntWidth'(1);
        end
        if (storeEn) begin
            wrPtr_d = ptrInc(wrPtr_q);
        end
        if (popStored) begin
            rdPtr_d = ptrInc(rdPtr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            creditCnt_q <= '0;
            fifoCount_q <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
        end else begin
            creditCnt_q <= creditCnt_d;
            fifoCount_q <= fifoCount_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (storeEn) begin
            rspData_q[wrPtr_q] <= pushData;
            rspId_q[wrPtr_q]   <= pushId;
            rspErr_q[wrPtr_q]  <= pushErr;
        end
    end

    assign obi_rvalid_o = rvalid;
    assign obi_rdata_o  = !rvalid ? '0 : (fifoEmpty ? pushData : rspData_q[rdPtr_q]);
    assign obi_rid_o    = !rvalid ? '0 : (fifoEmpty ? pushId : rspId_q[rdPtr_q]);
    assign obi_err_o    = rvalid && (fifoEmpty ? pushErr : rspErr_q[rdPtr_q]);

    // The credit count is exactly the number of transfers not yet popped.
    assert property (@(posedge clk_i) disable iff (rst_i)
        int'(creditCnt_q) == $countones(pipeValid_q) + int'(fifoCount_q));
    assert property (@(posedge clk_i) disable iff (rst_i) creditCnt_q <= DepthCnt);
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(storeEn && !popStored && fifoCount_q == DepthCnt));

endmodule

// File: tb/tb_idma_obi_sram_adapter.sv
// Randomized and directed bench for idma_obi_sram_adapter with SramLatency 1 and 2,
// checked against a transaction-level model of credits, memory and response ordering.
module tb_idma_obi_sram_adapter;

    localparam int NumDut = 2;
    localparam int Depth  = 2;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [0:0]  id;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [NumDut];
    logic        req    [NumDut];
    logic        gnt    [NumDut];
    logic [31:0] addr   [NumDut];
    logic        we     [NumDut];
    logic [3:0]  be     [NumDut];
    logic [31:0] wdata  [NumDut];
    logic [0:0]  aid    [NumDut];
    logic        rvalid [NumDut];
    logic        rready [NumDut];
    logic [31:0] rdata  [NumDut];
    logic [0:0]  rid    [NumDut];
    logic        err    [NumDut];
    logic        sreq   [NumDut];
    logic        swe    [NumDut];
    logic [9:0]  saddr  [NumDut];
    logic [3:0]  sbe    [NumDut];
    logic [31:0] swdata [NumDut];
    logic        lastGnt[NumDut];

    int assertCount = 0;
    int failCount   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic string tagOf(input int d, input string s);
        return $sformatf("dut%0d_%s", d, s);
    endfunction

    for (genvar g = 0; g < NumDut; g++) begin : gDut
        localparam int Lat = (g == 0) ? 1 : 2;

        logic [31:0] srdataL;
        logic [31:0] refMem  [1024];
        logic [31:0] sramMem [1024];
        rsp_t        expQ[$];
        int          cyc = 0;

        idma_obi_sram_adapter #(
            .AddrWidth    (32),
            .DataWidth    (32),
            .IdWidth      (1),
            .SramAddrWidth(10),
            .SramLatency  (Lat),
            .RspFifoDepth (Depth)
        ) dut (
            .clk_i       (clk),
            .rst_i       (rst[g]),
            .obi_req_i   (req[g]),
            .obi_gnt_o   (gnt[g]),
            .obi_addr_i  (addr[g]),
            .obi_we_i    (we[g]),
            .obi_be_i    (be[g]),
            .obi_wdata_i (wdata[g]),
            .obi_aid_i   (aid[g]),
            .obi_rvalid_o(rvalid[g]),
            .obi_rready_i(rready[g]),
            .obi_rdata_o (rdata[g]),
            .obi_rid_o   (rid[g]),
            .obi_err_o   (err[g]),
            .sram_req_o  (sreq[g]),
            .sram_we_o   (swe[g]),
            .sram_addr_o (saddr[g]),
            .sram_be_o   (sbe[g]),
            .sram_wdata_o(swdata[g]),
            .sram_rdata_i(srdataL)
        );

        // Behavioural SRAM: preloaded, returns read data Lat cycles after the strobe, garbage otherwise.
        initial begin
            logic        capReq, capWe;
            logic [9:0]  capAddr;
            logic [3:0]  capBe;
            logic [31:0] capWdata;
            logic        dlyValid [Lat];
            logic [31:0] dlyData  [Lat];
            for (int i = 0; i < 1024; i++) begin
                sramMem[i] = $urandom;
                refMem[i]  = sramMem[i];
            end
            for (int i = 0; i < Lat; i++) begin
                dlyValid[i] = 1'b0;
                dlyData[i]  = '0;
            end
            srdataL = '0;
            forever begin
                @(negedge clk);
                capReq = sreq[g]; capWe = swe[g]; capAddr = saddr[g];
                capBe = sbe[g]; capWdata = swdata[g];
                @(posedge clk);
                #1;
                for (int i = Lat - 1; i > 0; i--) begin
                    dlyValid[i] = dlyValid[i-1];
                    dlyData[i]  = dlyData[i-1];
                end
                dlyValid[0] = capReq && !capWe;
                dlyData[0]  = sramMem[capAddr];
                if (capReq && capWe) begin
                    for (int b = 0; b < 4; b++) begin
                        if (capBe[b]) sramMem[capAddr][8*b +: 8] = capWdata[8*b +: 8];
                    end
                end
                srdataL = dlyValid[Lat-1] ? dlyData[Lat-1] : $urandom;
            end
        end

        // Reference model: outstanding transfers form an in-order queue, each due Lat cycles after acceptance.
        initial begin
            logic       expRvalid, expPop, expGnt, expSreq, oor;
            logic [9:0] wa;
            rsp_t       entry;
            forever begin
                @(negedge clk);
                if (rst[g]) begin
                    expQ.delete();
                    checkOutput(tagOf(g, "rst_gnt"), gnt[g], 0);
                    checkOutput(tagOf(g, "rst_rvalid"), rvalid[g], 0);
                    checkOutput(tagOf(g, "rst_rdata"), rdata[g], 0);
                    checkOutput(tagOf(g, "rst_rid"), rid[g], 0);
                    checkOutput(tagOf(g, "rst_err"), err[g], 0);
                    checkOutput(tagOf(g, "rst_sreq"), sreq[g], 0);
                    checkOutput(tagOf(g, "rst_swe"), swe[g], 0);
                    checkOutput(tagOf(g, "rst_saddr"), saddr[g], 0);
                    checkOutput(tagOf(g, "rst_sbe"), sbe[g], 0);
                    checkOutput(tagOf(g, "rst_swdata"), swdata[g], 0);
                end else begin
                    expRvalid = (expQ.size() > 0) && (expQ[0].due <= cyc);
                    checkOutput(tagOf(g, "rvalid"), rvalid[g], expRvalid);
                    if (expRvalid) begin
                        checkOutput(tagOf(g, "rdata"), rdata[g], expQ[0].data);
                        checkOutput(tagOf(g, "rid"), rid[g], expQ[0].id);
                        checkOutput(tagOf(g, "err"), err[g], expQ[0].err);
                    end
                    expPop = expRvalid && rready[g];
                    expGnt = req[g] && ((expQ.size() < Depth) || expPop);
                    checkOutput(tagOf(g, "gnt"), gnt[g], expGnt);
                    oor     = |addr[g][31:12];
                    wa      = addr[g][11:2];
                    expSreq = expGnt && !oor;
                    checkOutput(tagOf(g, "sram_req"), sreq[g], expSreq);
                    if (expSreq) begin
                        checkOutput(tagOf(g, "sram_addr"), saddr[g], wa);
                        checkOutput(tagOf(g, "sram_we"), swe[g], we[g]);
                        checkOutput(tagOf(g, "sram_be"), sbe[g], be[g]);
                        checkOutput(tagOf(g, "sram_wdata"), swdata[g], wdata[g]);
                    end
                    if (expPop) void'(expQ.pop_front());
                    if (expGnt) begin
                        entry.due  = cyc + Lat;
                        entry.id   = aid[g];
                        entry.err  = oor;
                        entry.data = (!we[g] && !oor) ? refMem[wa] : 32'h0;
                        if (we[g] && !oor) begin
                            for (int b = 0; b < 4; b++) begin
                                if (be[g][b]) refMem[wa][8*b +: 8] = wdata[g][8*b +: 8];
                            end
                        end
                        expQ.push_back(entry);
                    end
                end
                lastGnt[g] = gnt[g];
                cyc++;
            end
        end
    end

    task automatic applyStimulus(input int d, input logic r, input logic w, input logic [31:0] a,
                                 input logic [3:0] b, input logic [31:0] wd, input logic [0:0] id,
                                 input logic rr);
        req[d] = r; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd; aid[d] = id; rready[d] = rr;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randAddr;
        return {20'h0, 5'h0, 5'($urandom_range(0, 31)), 2'($urandom)};
    endfunction

    initial begin
        int gntCount, rspCount;
        for (int d = 0; d < NumDut; d++) begin
            rst[d] = 1'b1;
            applyStimulus(d, 0, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
        end
        repeat (2) nextCycle;
        for (int d = 0; d < NumDut; d++) rst[d] = 1'b0;

        @(negedge clk);
        checkOutput("post_rst_rvalid", rvalid[0], 0);
        checkOutput("post_rst_rdata", rdata[0], 0);
        checkOutput("post_rst_sreq", sreq[0], 0);
        nextCycle;

        // Write then read back the same word
        applyStimulus(0, 1, 1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1);
        @(negedge clk);
        checkOutput("wr_gnt", gnt[0], 1);
        checkOutput("wr_sram_addr", saddr[0], 10'd4);
        nextCycle;
        applyStimulus(0, 1, 0, 32'h10, 4'hF, 32'h0, 1'b1, 1);
        @(negedge clk);
        checkOutput("rd_sram_addr", saddr[0], 10'd4);
        checkOutput("wr_rsp_valid", rvalid[0], 1);
        checkOutput("wr_rsp_rdata", rdata[0], 0);
        nextCycle;
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
        @(negedge clk);
        checkOutput("rd_rsp_valid", rvalid[0], 1);
        checkOutput("rd_rsp_rdata", rdata[0], 32'hDEADBEEF);
        checkOutput("rd_rsp_rid", rid[0], 1);
        checkOutput("rd_rsp_err", err[0], 0);
        nextCycle;

        // Eight back-to-back writes with rready high
        gntCount = 0; rspCount = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) applyStimulus(0, 1, 1, randAddr(), 4'($urandom), $urandom, 1'(i), 1);
            else       applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
            @(negedge clk);
            gntCount += int'(gnt[0]);
            rspCount += int'(rvalid[0]);
            nextCycle;
        end
        checkOutput("b2b_grants", gntCount, 8);
        checkOutput("b2b_responses", rspCount, 8);

        // Backpressure: only Depth grants, then one pop frees one grant in the same cycle
        gntCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 32'h20, 4'hF, 32'h0, 1'(i), 0);
            @(negedge clk);
            gntCount += int'(gnt[0]);
            nextCycle;
        end
        checkOutput("bp_grants", gntCount, Depth);
        applyStimulus(0, 1, 0, 32'h20, 4'hF, 32'h0, 1'b1, 1);
        @(negedge clk);
        checkOutput("bp_pop_rvalid", rvalid[0], 1);
        checkOutput("bp_regrant", gnt[0], 1);
        nextCycle;
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
        repeat (4) nextCycle;

        // Out-of-range read
        applyStimulus(0, 1, 0, 32'h0000_1000, 4'hF, 32'h0, 1'b0, 1);
        @(negedge clk);
        checkOutput("oor_gnt", gnt[0], 1);
        checkOutput("oor_sram_req", sreq[0], 0);
        nextCycle;
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
        @(negedge clk);
        checkOutput("oor_rvalid", rvalid[0], 1);
        checkOutput("oor_err", err[0], 1);
        checkOutput("oor_rdata", rdata[0], 0);
        nextCycle;

        // Latency 2: continuous reads at full throughput
        gntCount = 0; rspCount = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 10) applyStimulus(1, 1, 0, randAddr(), 4'hF, 32'h0, 1'(i), 1);
            else        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
            @(negedge clk);
            gntCount += int'(gnt[1]);
            rspCount += int'(rvalid[1]);
            nextCycle;
        end
        checkOutput("lat2_grants", gntCount, 10);
        checkOutput("lat2_responses", rspCount, 10);

        // Reset with transfers outstanding: nothing stale may come back
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 0, randAddr(), 4'hF, 32'h0, 1'b1, 0);
            nextCycle;
        end
        rst[1] = 1'b1;
        @(negedge clk);
        checkOutput("rst_inflight_rvalid", rvalid[1], 0);
        checkOutput("rst_inflight_gnt", gnt[1], 0);
        nextCycle;
        rst[1] = 1'b0;
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
        rspCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rspCount += int'(rvalid[1]);
            nextCycle;
        end
        checkOutput("no_stale_rsp", rspCount, 0);
        applyStimulus(1, 1, 0, 32'h8, 4'hF, 32'h0, 1'b1, 1);
        nextCycle;
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
        repeat (3) nextCycle;

        // Random traffic on both instances; a pending request is held until granted
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < NumDut; d++) begin
                if (!(req[d] && !lastGnt[d])) begin
                    applyStimulus(d, ($urandom_range(0, 3) != 0), 1'($urandom),
                                  ($urandom_range(0, 15) == 0) ? ($urandom | 32'h0000_1000) : randAddr(),
                                  4'($urandom), $urandom, 1'($urandom), 1'b1);
                end
                rready[d] = ($urandom_range(0, 3) != 0);
            end
            nextCycle;
        end
        for (int d = 0; d < NumDut; d++) applyStimulus(d, 0, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
        repeat (6) nextCycle;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
